// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory port arbiter: default bus widths,
// FSM state encoding and read-owner encoding.
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RD_WAIT = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } rd_owner_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-RAM arbiter between an instruction-fetch port and a data port.
// Data has priority; a starvation counter eventually forces a fetch grant.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_rw,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned LAT_W = 2;
  localparam int unsigned SC_W  = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  arb_state_e        state_q,      state_d;
  rd_owner_e         owner_q,      owner_d;
  logic [LAT_W-1:0]  lat_cnt_q,    lat_cnt_d;
  logic [SC_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic              if_rvalid_q,  if_rvalid_d;
  logic              d_rvalid_q,   d_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q,   if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q,    d_rdata_d;
  logic              fetch_wins;

  // Arbitration, RAM strobe generation and read-completion tracking.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    if_rvalid_d  = 1'b0;
    d_rvalid_d   = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    fetch_wins   = 1'b0;
    if_gnt       = 1'b0;
    d_gnt        = 1'b0;
    mem_en       = 1'b0;
    mem_rw       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;

    case (state_q)
      ST_IDLE: begin
        if (!rst) begin
          fetch_wins = if_req && (!d_req || (starve_cnt_q == SC_W'(STARVE_MAX)));
          if (fetch_wins) begin
            if_gnt       = 1'b1;
            mem_en       = 1'b1;
            mem_addr     = if_addr;
            starve_cnt_d = '0;
            owner_d      = OWN_IF;
            lat_cnt_d    = LAT_W'(RD_LAT - 1);
            state_d      = ST_RD_WAIT;
          end else if (d_req) begin
            d_gnt     = 1'b1;
            mem_en    = 1'b1;
            mem_rw    = d_rw;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            if (if_req) begin
              starve_cnt_d = SC_W'(starve_cnt_q + 1'b1);
            end
            // Writes finish in the grant cycle; only reads occupy the port.
            if (!d_rw) begin
              owner_d   = OWN_D;
              lat_cnt_d = LAT_W'(RD_LAT - 1);
              state_d   = ST_RD_WAIT;
            end
          end
        end
      end
      ST_RD_WAIT: begin
        if (lat_cnt_q == '0) begin
          state_d = ST_IDLE;
          if (owner_q == OWN_IF) begin
            if_rdata_d  = mem_rdata;
            if_rvalid_d = 1'b1;
          end else begin
            d_rdata_d  = mem_rdata;
            d_rvalid_d = 1'b1;
          end
        end else begin
          lat_cnt_d = LAT_W'(lat_cnt_q - 1'b1);
        end
      end
    endcase
  end

  // State and response registers; reset drops any read in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_IF;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
      if_rvalid_q  <= 1'b0;
      d_rvalid_q   <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      if_rvalid_q  <= if_rvalid_d;
      d_rvalid_q   <= d_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with RD_LAT=1 and one with
// RD_LAT=3, each backed by a small latency-matched RAM model.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;

  logic          clk;
  logic          rst;
  logic          if_req, d_req, d_rw;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata;

  logic          if_gnt_1, if_rvalid_1, d_gnt_1, d_rvalid_1, mem_en_1, mem_rw_1, busy_1;
  logic [DW-1:0] if_rdata_1, d_rdata_1, mem_wdata_1, mem_rdata_1;
  logic [AW-1:0] mem_addr_1;
  logic          if_gnt_3, if_rvalid_3, d_gnt_3, d_rvalid_3, mem_en_3, mem_rw_3, busy_3;
  logic [DW-1:0] if_rdata_3, d_rdata_3, mem_wdata_3, mem_rdata_3;
  logic [AW-1:0] mem_addr_3;

  int n_chk;
  int n_pass;
  int ngr;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .STARVE_MAX(4)) u_dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_1),
    .if_rvalid(if_rvalid_1), .if_rdata(if_rdata_1),
    .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt_1), .d_rvalid(d_rvalid_1), .d_rdata(d_rdata_1),
    .mem_en(mem_en_1), .mem_rw(mem_rw_1), .mem_addr(mem_addr_1),
    .mem_wdata(mem_wdata_1), .mem_rdata(mem_rdata_1), .busy(busy_1)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .STARVE_MAX(4)) u_dut3 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_3),
    .if_rvalid(if_rvalid_3), .if_rdata(if_rdata_3),
    .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt_3), .d_rvalid(d_rvalid_3), .d_rdata(d_rdata_3),
    .mem_en(mem_en_3), .mem_rw(mem_rw_3), .mem_addr(mem_addr_3),
    .mem_wdata(mem_wdata_3), .mem_rdata(mem_rdata_3), .busy(busy_3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input logic [7:0] a);
    return (a == 8'h10) ? 32'hDEADBEEF : {8'hC0, a, 8'h5A, ~a};
  endfunction

  // RAM models: address captured at the access edge, data presented RD_LAT cycles later.
  logic [DW-1:0] ram1 [256];
  logic [DW-1:0] ram3 [256];
  logic [255:0]  wr1, wr3;
  logic [7:0]    pipe1;
  logic [7:0]    pipe3 [3];

  always @(posedge clk) begin
    if (rst) begin
      wr1 <= '0;
    end else if (mem_en_1 && mem_rw_1) begin
      ram1[mem_addr_1[7:0]] <= mem_wdata_1;
      wr1[mem_addr_1[7:0]]  <= 1'b1;
    end
    pipe1 <= mem_addr_1[7:0];
  end

  always @(posedge clk) begin
    if (rst) begin
      wr3 <= '0;
    end else if (mem_en_3 && mem_rw_3) begin
      ram3[mem_addr_3[7:0]] <= mem_wdata_3;
      wr3[mem_addr_3[7:0]]  <= 1'b1;
    end
    pipe3[0] <= mem_addr_3[7:0];
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end

  assign mem_rdata_1 = wr1[pipe1] ? ram1[pipe1] : init_word(pipe1);
  assign mem_rdata_3 = wr3[pipe3[2]] ? ram3[pipe3[2]] : init_word(pipe3[2]);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_rw    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
  endtask

  task automatic chk_zero1(input string tag);
    chk({tag, "_ctl"}, 32'({if_gnt_1, d_gnt_1, if_rvalid_1, d_rvalid_1, mem_en_1, mem_rw_1, busy_1}), 32'd0);
    chk({tag, "_maddr"}, 32'(mem_addr_1), 32'd0);
    chk({tag, "_mwdata"}, mem_wdata_1, 32'd0);
    chk({tag, "_if_rdata"}, if_rdata_1, 32'd0);
    chk({tag, "_d_rdata"}, d_rdata_1, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b1;
    idle_inputs();

    // Reset state, with a fetch request held to show no grant under reset.
    tick(); if_req = 1'b1; if_addr = 16'h0010; samp();
    chk_zero1("rst_init");
    chk("rst_busy3", 32'({busy_3, if_gnt_3, mem_en_3}), 32'd0);
    tick(); rst = 1'b0; idle_inputs(); samp();
    chk_zero1("rst_rel0");

    // Lone fetch read, RD_LAT=1.
    tick(); if_req = 1'b1; if_addr = 16'h0010; samp();
    chk("f_gnt", 32'(if_gnt_1), 32'd1);
    chk("f_d_gnt", 32'(d_gnt_1), 32'd0);
    chk("f_mem_en", 32'(mem_en_1), 32'd1);
    chk("f_mem_rw", 32'(mem_rw_1), 32'd0);
    chk("f_mem_addr", 32'(mem_addr_1), 32'h10);
    tick(); idle_inputs(); samp();
    chk("f_busy_c1", 32'(busy_1), 32'd1);
    chk("f_rvalid_c1", 32'(if_rvalid_1), 32'd0);
    tick(); samp();
    chk("f_rvalid_c2", 32'(if_rvalid_1), 32'd1);
    chk("f_rdata_c2", if_rdata_1, 32'hDEADBEEF);
    chk("f_busy_c2", 32'(busy_1), 32'd0);
    tick(); samp();
    chk("f_rvalid_c3", 32'(if_rvalid_1), 32'd0);
    chk("f_rdata_hold", if_rdata_1, 32'hDEADBEEF);
    repeat (3) tick();

    // Data write completes in the grant cycle.
    tick(); d_req = 1'b1; d_rw = 1'b1; d_addr = 16'h1234; d_wdata = 32'hA5A5A5A5; samp();
    chk("w_gnt", 32'(d_gnt_1), 32'd1);
    chk("w_mem_en", 32'(mem_en_1), 32'd1);
    chk("w_mem_rw", 32'(mem_rw_1), 32'd1);
    chk("w_mem_addr", 32'(mem_addr_1), 32'h1234);
    chk("w_mem_wdata", mem_wdata_1, 32'hA5A5A5A5);
    chk("w_busy_c0", 32'(busy_1), 32'd0);
    tick(); idle_inputs(); samp();
    chk("w_busy_c1", 32'(busy_1), 32'd0);
    chk("w_rvalid_c1", 32'(d_rvalid_1), 32'd0);
    tick(); samp();
    chk("w_rvalid_c2", 32'(d_rvalid_1), 32'd0);
    tick(); d_req = 1'b1; d_rw = 1'b0; d_addr = 16'h1234; samp();
    chk("wr_rd_gnt", 32'(d_gnt_1), 32'd1);
    chk("wr_rd_rw", 32'(mem_rw_1), 32'd0);
    tick(); idle_inputs();
    tick(); samp();
    chk("wr_rd_rvalid", 32'(d_rvalid_1), 32'd1);
    chk("wr_rd_rdata", d_rdata_1, 32'hA5A5A5A5);
    chk("if_rdata_kept", if_rdata_1, 32'hDEADBEEF);
    repeat (4) tick();

    // Both ports hammering: four data grants, then fetch forced, pattern repeats.
    tick(); if_req = 1'b1; if_addr = 16'h0030; d_req = 1'b1; d_rw = 1'b0; d_addr = 16'h0020;
    ngr = 0;
    for (int cyc = 0; cyc < 40 && ngr < 10; cyc++) begin
      samp();
      chk($sformatf("one_gnt_%0d", cyc), 32'(if_gnt_1 & d_gnt_1), 32'd0);
      if (if_gnt_1 || d_gnt_1) begin
        chk($sformatf("starve_g%0d", ngr), 32'(if_gnt_1), 32'((ngr == 4) || (ngr == 9)));
        ngr++;
      end
      if (ngr < 10) tick();
    end
    chk("starve_ngrants", 32'(ngr), 32'd10);
    tick(); idle_inputs();
    repeat (6) tick();

    // RD_LAT=3 data read; a fetch arriving in RD_WAIT waits for IDLE.
    tick(); d_req = 1'b1; d_rw = 1'b0; d_addr = 16'h0044; samp();
    chk("l3_gnt", 32'(d_gnt_3), 32'd1);
    chk("l3_busy_c0", 32'(busy_3), 32'd0);
    tick(); idle_inputs(); if_req = 1'b1; if_addr = 16'h0050;
    for (int c = 1; c <= 3; c++) begin
      samp();
      chk($sformatf("l3_busy_c%0d", c), 32'(busy_3), 32'd1);
      chk($sformatf("l3_if_gnt_c%0d", c), 32'(if_gnt_3), 32'd0);
      chk($sformatf("l3_rvalid_c%0d", c), 32'(d_rvalid_3), 32'd0);
      tick();
    end
    samp();
    chk("l3_rvalid_c4", 32'(d_rvalid_3), 32'd1);
    chk("l3_rdata_c4", d_rdata_3, init_word(8'h44));
    chk("l3_busy_c4", 32'(busy_3), 32'd0);
    chk("l3_if_gnt_c4", 32'(if_gnt_3), 32'd1);
    tick(); idle_inputs();
    repeat (6) tick();

    // Reset in the cycle after a read grant abandons the read.
    tick(); d_req = 1'b1; d_rw = 1'b0; d_addr = 16'h0020; samp();
    chk("rr_gnt", 32'(d_gnt_1), 32'd1);
    tick(); idle_inputs(); rst = 1'b1; samp();
    chk("rr_busy_c1", 32'(busy_1), 32'd1);
    tick(); if_req = 1'b1; if_addr = 16'h0010; samp();
    chk_zero1("rr_c2");
    chk("rr_dut3_c2", 32'({busy_3, if_gnt_3, d_rvalid_3}), 32'd0);
    tick(); rst = 1'b0; idle_inputs(); samp();
    chk_zero1("rr_c3");
    for (int c = 4; c < 8; c++) begin
      tick(); samp();
      chk($sformatf("rr_norv_c%0d", c), 32'({d_rvalid_1, d_rvalid_3, if_rvalid_1}), 32'd0);
    end

    // Address change after the grant cycle must not affect the access.
    tick(); d_req = 1'b1; d_rw = 1'b0; d_addr = 16'h0060; samp();
    chk("as_mem_addr_c0", 32'(mem_addr_1), 32'h60);
    tick(); d_req = 1'b0; d_addr = 16'h0070; samp();
    chk("as_mem_addr_c1", 32'(mem_addr_1), 32'd0);
    tick(); samp();
    chk("as_rvalid_c2", 32'(d_rvalid_1), 32'd1);
    chk("as_rdata_c2", d_rdata_1, init_word(8'h60));
    tick(); idle_inputs();
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
